// File: rtl/eth_tx_arb_if.sv
// eth_tx_arb_if: source-side and MAC-side AXI-Stream bundle of the TX arbiter plus its status lines
interface eth_tx_arb_if;
  logic [23:0] tx_axis_src_tdata;
  logic [2:0]  tx_axis_src_tvalid;
  logic [2:0]  tx_axis_src_tlast;
  logic [2:0]  tx_axis_src_tready;
  logic [7:0]  tx_axis_mac_tdata;
  logic        tx_axis_mac_tvalid;
  logic        tx_axis_mac_tlast;
  logic        tx_axis_mac_tuser;
  logic        tx_axis_mac_tready;
  logic [2:0]  tx_arb_grant;
  logic        tx_arb_timeout;
  modport master (
    input  tx_axis_src_tdata, tx_axis_src_tvalid, tx_axis_src_tlast, tx_axis_mac_tready,
    output tx_axis_src_tready, tx_axis_mac_tdata, tx_axis_mac_tvalid, tx_axis_mac_tlast,
    output tx_axis_mac_tuser, tx_arb_grant, tx_arb_timeout
  );
  modport slave (
    output tx_axis_src_tdata, tx_axis_src_tvalid, tx_axis_src_tlast, tx_axis_mac_tready,
    input  tx_axis_src_tready, tx_axis_mac_tdata, tx_axis_mac_tvalid, tx_axis_mac_tlast,
    input  tx_axis_mac_tuser, tx_arb_grant, tx_arb_timeout
  );
endinterface

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-granular round-robin arbiter of three TX sources onto the MAC byte stream, with idle gap and stall watchdog
module eth_tx_arb #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 2047
) (
  input logic          tx_mac_aclk,
  input logic          tx_mac_reset,
  eth_tx_arb_if.master bus
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GRANT, ABORT, GAP} state_t;
  localparam state_t END_ST = (GAP_CYCLES == 0) ? IDLE : GAP;
  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    discard_q, discard_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          timeout_q, timeout_d;
  logic [2:0]    sel, elig;
  logic [1:0]    c0, c1, pick;
  logic [7:0]    s_data;
  logic          s_valid, s_last, m_ready, xfer;
  assign sel     = 3'b001 << last_q;
  assign elig    = bus.tx_axis_src_tvalid & ~discard_q;
  assign c0      = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
  assign c1      = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
  assign pick    = elig[c0] ? c0 : elig[c1] ? c1 : last_q;
  assign s_data  = (last_q == 2'd0) ? bus.tx_axis_src_tdata[7:0] :
                   (last_q == 2'd1) ? bus.tx_axis_src_tdata[15:8] : bus.tx_axis_src_tdata[23:16];
  assign s_valid = |(bus.tx_axis_src_tvalid & sel);
  assign s_last  = |(bus.tx_axis_src_tlast & sel);
  assign m_ready = bus.tx_axis_mac_tready;
  assign xfer    = s_valid & m_ready;
  assign bus.tx_axis_mac_tdata  = (state_q == GRANT) ? s_data : 8'h00;
  assign bus.tx_axis_mac_tvalid = (state_q == GRANT) ? s_valid : (state_q == ABORT);
  assign bus.tx_axis_mac_tlast  = (state_q == GRANT) ? s_last : (state_q == ABORT);
  assign bus.tx_axis_mac_tuser  = (state_q == ABORT);
  assign bus.tx_axis_src_tready = discard_q | ((state_q == GRANT) ? (sel & {3{m_ready}}) : 3'b000);
  assign bus.tx_arb_grant       = grant_q;
  assign bus.tx_arb_timeout     = timeout_q;
  // Next-state: arbitration, frame tracking, watchdog, gap timing and discard bookkeeping
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    discard_d = discard_q & ~(bus.tx_axis_src_tvalid & bus.tx_axis_src_tlast);
    wd_d      = wd_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (|elig) begin
        state_d = GRANT;
        last_d  = pick;
        grant_d = 3'b001 << pick;
        wd_d    = '0;
      end
      GRANT: if (xfer && s_last) begin
        state_d = END_ST;
        grant_d = '0;
        gap_d   = '0;
        wd_d    = '0;
      end else if (xfer || !m_ready) begin
        wd_d = '0;
      end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ABORT;
        grant_d   = '0;
        timeout_d = 1'b1;
        wd_d      = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      ABORT: if (m_ready) begin
        state_d   = END_ST;
        discard_d = discard_d | sel;
        gap_d     = '0;
      end
      GAP: if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
      else gap_d = gap_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs; reset drops any frame in flight without an abort byte
  always_ff @(posedge tx_mac_aclk or posedge tx_mac_reset)
    if (tx_mac_reset) begin
      state_q   <= IDLE;
      last_q    <= 2'd2;
      grant_q   <= '0;
      discard_q <= '0;
      wd_q      <= '0;
      gap_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      discard_q <= discard_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      timeout_q <= timeout_d;
    end
endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed checks of eth_tx_arb arbitration, gap, watchdog abort, discard and reset
module tb_eth_tx_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic tog = 1'b0;
  logic [1:0] ph = 2'd0;
  int errs = 0;
  int nchk = 0;
  int tcnt = 0;
  int ucnt = 0;
  int t0;
  logic [7:0] mem [3][256];
  logic       lf  [3][256];
  int len [3];
  int ptr [3];
  logic [7:0] cap_d [$];
  logic       cap_l [$];
  logic       cap_u [$];
  int         cap_s [$];
  logic [7:0] ad;
  logic       al, au;
  int         as;
  eth_tx_arb_if bus();
  eth_tx_arb dut (.tx_mac_aclk(clk), .tx_mac_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.tx_axis_mac_tready = tog ? (ph == 2'd0) : rdy;
  // Source models: each presents its queued bytes in order and advances on acceptance
  always_comb begin
    bus.tx_axis_src_tdata  = '0;
    bus.tx_axis_src_tvalid = '0;
    bus.tx_axis_src_tlast  = '0;
    for (int i = 0; i < 3; i++) begin
      bus.tx_axis_src_tvalid[i]      = ptr[i] < len[i];
      bus.tx_axis_src_tlast[i]       = lf[i][ptr[i][7:0]];
      bus.tx_axis_src_tdata[8*i +: 8] = mem[i][ptr[i][7:0]];
    end
  end
  always @(posedge clk) begin
    ph <= ph + 2'd1;
    for (int i = 0; i < 3; i++)
      if (ptr[i] < len[i] && bus.tx_axis_src_tready[i]) ptr[i] <= ptr[i] + 1;
  end
  // MAC-side monitor: record every accepted byte with the source that held the grant
  always @(posedge clk) begin
    if (bus.tx_axis_mac_tvalid && bus.tx_axis_mac_tready) begin
      cap_d.push_back(bus.tx_axis_mac_tdata);
      cap_l.push_back(bus.tx_axis_mac_tlast);
      cap_u.push_back(bus.tx_axis_mac_tuser);
      cap_s.push_back(bus.tx_arb_grant == 3'b001 ? 0 : bus.tx_arb_grant == 3'b010 ? 1 :
                      bus.tx_arb_grant == 3'b100 ? 2 : 3);
      if (bus.tx_axis_mac_tuser) ucnt <= ucnt + 1;
    end
    if (bus.tx_arb_timeout) tcnt <= tcnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic push_byte(input int s, input logic [7:0] d, input logic l);
    mem[s][len[s]] = d;
    lf[s][len[s]]  = l;
    len[s]++;
  endtask
  task automatic push_frame(input int s, input int n, input logic [7:0] seed, input logic wl);
    for (int k = 0; k < n; k++) push_byte(s, seed + 8'(k), wl && (k == n - 1));
  endtask
  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
    cap_u.delete();
    cap_s.delete();
  endtask
  task automatic pop_cap();
    ad = cap_d.pop_front();
    al = cap_l.pop_front();
    au = cap_u.pop_front();
    as = cap_s.pop_front();
  endtask
  task automatic wait_cap(input string tag, input int n, input int budget);
    int b = budget;
    while (cap_d.size() < n && b > 0) begin @(negedge clk); b--; end
    chk({tag, "_wait_bytes"}, cap_d.size() >= n, 1);
  endtask
  task automatic wait_grant(input string tag, input logic [2:0] g, input int budget);
    int b = budget;
    while (bus.tx_arb_grant !== g && b > 0) begin @(negedge clk); b--; end
    chk({tag, "_wait_grant"}, bus.tx_arb_grant, g);
  endtask
  task automatic wait_drained(input string tag, input int s, input int budget);
    int b = budget;
    while (ptr[s] < len[s] && b > 0) begin @(negedge clk); b--; end
    chk({tag, "_drained"}, ptr[s] == len[s], 1);
  endtask
  task automatic check_frame(input string tag, input int s, input int n, input logic [7:0] seed, input logic lastexp);
    int bad = 0;
    chk({tag, "_count"}, cap_d.size() >= n, 1);
    for (int k = 0; k < n; k++) begin
      if (cap_d.size() == 0) bad++;
      else begin
        pop_cap();
        if (ad !== seed + 8'(k) || al !== ((k == n - 1) ? lastexp : 1'b0) || au !== 1'b0 || as != s) bad++;
      end
    end
    chk({tag, "_bad_bytes"}, bad, 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_cap();
  endtask
  initial begin
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 256; k++) begin
        mem[i][k] = 8'h00;
        lf[i][k]  = 1'b0;
      end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", bus.tx_arb_grant, 3'b000);
    chk("rst_mac_tvalid", bus.tx_axis_mac_tvalid, 1'b0);
    chk("rst_src_tready", bus.tx_axis_src_tready, 3'b000);
    chk("rst_timeout", bus.tx_arb_timeout, 1'b0);
    chk("rst_tuser", bus.tx_axis_mac_tuser, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // ARP 4-byte frame, free-flowing MAC
    @(negedge clk);
    push_byte(0, 8'h45, 1'b0);
    push_byte(0, 8'h00, 1'b0);
    push_byte(0, 8'h00, 1'b0);
    push_byte(0, 8'h1C, 1'b1);
    #1;
    chk("t1_arb_latency_grant", bus.tx_arb_grant, 3'b000);
    chk("t1_arb_latency_valid", bus.tx_axis_mac_tvalid, 1'b0);
    @(negedge clk);
    #1;
    chk("t1_grant", bus.tx_arb_grant, 3'b001);
    chk("t1_tvalid", bus.tx_axis_mac_tvalid, 1'b1);
    chk("t1_tdata0", bus.tx_axis_mac_tdata, 8'h45);
    chk("t1_src_tready", bus.tx_axis_src_tready, 3'b001);
    wait_cap("t1", 4, 20);
    #1;
    chk("t1_gap1_valid", bus.tx_axis_mac_tvalid, 1'b0);
    chk("t1_gap1_grant", bus.tx_arb_grant, 3'b000);
    @(negedge clk);
    #1;
    chk("t1_gap2_valid", bus.tx_axis_mac_tvalid, 1'b0);
    pop_cap(); chk("t1_b0", {ad, al, au}, {8'h45, 2'b00});
    pop_cap(); chk("t1_b1", {ad, al, au}, {8'h00, 2'b00});
    pop_cap(); chk("t1_b2", {ad, al, au}, {8'h00, 2'b00});
    pop_cap(); chk("t1_b3", {ad, al, au}, {8'h1C, 2'b10});
    // All three sources at once after reset, twice
    pulse_reset();
    @(negedge clk);
    push_frame(0, 3, 8'h10, 1'b1);
    push_frame(1, 3, 8'h20, 1'b1);
    push_frame(2, 3, 8'h30, 1'b1);
    @(negedge clk);
    #1;
    chk("t2_first_grant", bus.tx_arb_grant, 3'b001);
    chk("t2_others_blocked", bus.tx_axis_src_tready, 3'b001);
    wait_cap("t2a", 9, 60);
    check_frame("t2a_src0", 0, 3, 8'h10, 1'b1);
    check_frame("t2a_src1", 1, 3, 8'h20, 1'b1);
    check_frame("t2a_src2", 2, 3, 8'h30, 1'b1);
    repeat (4) @(negedge clk);
    push_frame(0, 3, 8'h40, 1'b1);
    push_frame(1, 3, 8'h50, 1'b1);
    push_frame(2, 3, 8'h60, 1'b1);
    wait_cap("t2b", 9, 60);
    check_frame("t2b_src0", 0, 3, 8'h40, 1'b1);
    check_frame("t2b_src1", 1, 3, 8'h50, 1'b1);
    check_frame("t2b_src2", 2, 3, 8'h60, 1'b1);
    // UDP 64 bytes under 1-on/3-off backpressure
    repeat (4) @(negedge clk);
    t0 = tcnt;
    tog = 1'b1;
    push_frame(2, 64, 8'h80, 1'b1);
    wait_cap("t3", 64, 400);
    check_frame("t3_udp64", 2, 64, 8'h80, 1'b1);
    repeat (10) @(negedge clk);
    chk("t3_no_extra", cap_d.size(), 0);
    chk("t3_no_timeout", tcnt, t0);
    tog = 1'b0;
    // UDP stalls after 10 bytes while ICMP waits
    @(negedge clk);
    push_frame(2, 10, 8'hA0, 1'b0);
    wait_grant("t4", 3'b100, 10);
    push_frame(1, 5, 8'hC0, 1'b1);
    wait_drained("t4_head", 2, 40);
    repeat (2046) @(negedge clk);
    #1;
    chk("t4_pre_timeout", bus.tx_arb_timeout, 1'b0);
    chk("t4_pre_grant", bus.tx_arb_grant, 3'b100);
    chk("t4_pre_tuser", bus.tx_axis_mac_tuser, 1'b0);
    @(negedge clk);
    #1;
    chk("t4_timeout_pulse", bus.tx_arb_timeout, 1'b1);
    chk("t4_abort_byte", {bus.tx_axis_mac_tvalid, bus.tx_axis_mac_tdata, bus.tx_axis_mac_tlast, bus.tx_axis_mac_tuser}, {1'b1, 8'h00, 2'b11});
    chk("t4_abort_grant", bus.tx_arb_grant, 3'b000);
    chk("t4_abort_src_tready", bus.tx_axis_src_tready, 3'b000);
    rdy = 1'b0;
    @(negedge clk);
    #1;
    chk("t4_pulse_one_cycle", bus.tx_arb_timeout, 1'b0);
    chk("t4_abort_hold", {bus.tx_axis_mac_tvalid, bus.tx_axis_mac_tuser}, 2'b11);
    rdy = 1'b1;
    wait_cap("t4", 16, 60);
    check_frame("t4_udp_head", 2, 10, 8'hA0, 1'b0);
    pop_cap();
    chk("t4_abort_cap", {ad, al, au}, {8'h00, 2'b11});
    check_frame("t4_icmp", 1, 5, 8'hC0, 1'b1);
    chk("t4_timeout_count", tcnt, t0 + 1);
    push_frame(2, 10, 8'hAA, 1'b1);
    #1;
    chk("t4_discard_ready", bus.tx_axis_src_tready[2], 1'b1);
    wait_drained("t4_tail", 2, 30);
    repeat (4) @(negedge clk);
    chk("t4_tail_dropped", cap_d.size(), 0);
    chk("t4_discard_cleared", bus.tx_axis_src_tready, 3'b000);
    // tlast accepted exactly when the watchdog would expire
    push_frame(2, 2, 8'h50, 1'b0);
    wait_drained("t5_head", 2, 20);
    repeat (2046) @(negedge clk);
    push_byte(2, 8'h52, 1'b1);
    #1;
    chk("t5_last_presented", {bus.tx_axis_mac_tvalid, bus.tx_axis_mac_tlast, bus.tx_axis_mac_tuser}, 3'b110);
    chk("t5_grant", bus.tx_arb_grant, 3'b100);
    @(negedge clk);
    #1;
    chk("t5_no_timeout", bus.tx_arb_timeout, 1'b0);
    chk("t5_no_abort_byte", bus.tx_axis_mac_tvalid, 1'b0);
    wait_cap("t5", 3, 10);
    check_frame("t5_udp", 2, 3, 8'h50, 1'b1);
    chk("t5_timeout_count", tcnt, t0 + 1);
    // Reset in the middle of an ARP frame
    repeat (4) @(negedge clk);
    push_frame(0, 8, 8'h60, 1'b1);
    wait_grant("t6", 3'b001, 10);
    @(negedge clk);
    clear_cap();
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.tx_axis_mac_tvalid, 1'b0);
    chk("t6_rst_grant", bus.tx_arb_grant, 3'b000);
    chk("t6_rst_src_tready", bus.tx_axis_src_tready, 3'b000);
    chk("t6_rst_tuser_tlast", {bus.tx_axis_mac_tuser, bus.tx_axis_mac_tlast, bus.tx_arb_timeout}, 3'b000);
    push_frame(1, 3, 8'h70, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_after_reset_grant", bus.tx_arb_grant, 3'b001);
    wait_cap("t6", 10, 80);
    check_frame("t6_src0_rest", 0, 7, 8'h61, 1'b1);
    check_frame("t6_src1", 1, 3, 8'h70, 1'b1);
    chk("t6_abort_bytes_total", ucnt, 1);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
